// File: rtl/systolic_drain.sv
// Drains the N*N result slots of a systolic array one word per transfer over a valid/ready port.
// Results are snapshotted into shadow registers when done_in fires, so the array can keep working.
module systolic_drain #(
  parameter int N         = 2,
  parameter int ACC_WIDTH = 32,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_in,
  input  logic [5*N*N-1:0]           exp_in,
  input  logic [ACC_WIDTH*N*N-1:0]   acc_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [IDX_W-1:0]           out_idx,
  output logic [4:0]                 out_exp,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned           NN       = N * N;
  localparam int unsigned           DEPTH    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   overrun_q;

  // Sized to the full index range so any idx_q value addresses a real entry.
  logic [4:0]             exp_sh [DEPTH];
  logic [ACC_WIDTH-1:0]   acc_sh [DEPTH];

  logic                   draining;
  logic                   at_last;
  logic                   xfer;
  logic                   last_xfer;
  logic                   capture;
  logic                   drop;

  always_comb begin
    draining  = (state_q == DRAIN);
    at_last   = draining && (idx_q == LAST_IDX);
    xfer      = draining && out_ready;
    last_xfer = xfer && at_last;
    // A pulse landing on the final transfer is a clean back-to-back recapture.
    capture   = done_in && (!draining || last_xfer);
    drop      = done_in && draining && !last_xfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= DRAIN;
            idx_q   <= '0;
          end
        end
        DRAIN: begin
          if (capture) begin
            state_q <= DRAIN;
            idx_q   <= '0;
          end else if (last_xfer) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (xfer) begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned k = 0; k < NN; k++) begin
        exp_sh[k] <= exp_in[5*k +: 5];
        acc_sh[k] <= acc_in[ACC_WIDTH*k +: ACC_WIDTH];
      end
    end
  end

  always_comb begin
    busy      = draining;
    out_valid = draining;
    overrun   = overrun_q;
    out_last  = at_last;
    out_idx   = '0;
    out_exp   = '0;
    out_acc   = '0;
    if (draining) begin
      out_idx = idx_q;
      out_exp = exp_sh[idx_q];
      out_acc = acc_sh[idx_q];
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: stimulus pushes expected words, a monitor pops on each transfer.
module tb_systolic_drain;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic              done_in;
  logic [5*N*N-1:0]  exp_in;
  logic [AW*N*N-1:0] acc_in;
  logic              out_ready;
  logic              out_valid;
  logic [IW-1:0]     out_idx;
  logic [4:0]        out_exp;
  logic [AW-1:0]     out_acc;
  logic              out_last;
  logic              busy;
  logic              overrun;

  typedef struct {
    logic [IW-1:0] idx;
    logic [4:0]    exp;
    logic [AW-1:0] acc;
    logic          last;
  } word_t;

  word_t sb[$];
  int    total = 0;
  int    bad   = 0;

  systolic_drain #(.N(N), .ACC_WIDTH(AW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .exp_in    (exp_in),
    .acc_in    (acc_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_exp   (out_exp),
    .out_acc   (out_acc),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: transfers are sampled mid-cycle, away from the active edge.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      chk("valid_eq_busy", 64'(out_valid), 64'(busy));
      if (!out_valid) begin
        chk("idle_zero", {out_idx, out_exp, out_acc, out_last}, '0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'(out_idx), 64'hDEAD);
        end else begin
          w = sb.pop_front();
          chk("word_idx",  64'(out_idx),  64'(w.idx));
          chk("word_exp",  64'(out_exp),  64'(w.exp));
          chk("word_acc",  64'(out_acc),  64'(w.acc));
          chk("word_last", 64'(out_last), 64'(w.last));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a0, a1, a2, a3, input logic [4:0] e0, e1, e2, e3);
    acc_in = {a3, a2, a1, a0};
    exp_in = {e3, e2, e1, e0};
  endtask

  task automatic push(input logic [IW-1:0] i, input logic [4:0] e, input logic [AW-1:0] a);
    word_t w;
    w.idx  = i;
    w.exp  = e;
    w.acc  = a;
    w.last = (i == IW'(N*N-1));
    sb.push_back(w);
  endtask

  task automatic push_std();
    push(0, 5'd1, 32'd10);
    push(1, 5'd2, 32'd20);
    push(2, 5'd3, 32'd30);
    push(3, 5'd4, 32'd40);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    done_in   = 1'b0;
    out_ready = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_valid",   64'(out_valid), 64'd0);
    chk("rst_busy",    64'(busy),      64'd0);
    chk("rst_overrun", 64'(overrun),   64'd0);
    chk("rst_data",    {out_idx, out_exp, out_acc, out_last}, '0);
    #11 rst = 1'b1;
    cyc();

    // Basic drain with latency and timing of return to idle
    load(10, 20, 30, 40, 1, 2, 3, 4);
    done_in = 1'b1;
    push_std();
    cyc();
    done_in = 1'b0;
    chk("lat1_valid", 64'(out_valid), 64'd1);
    chk("lat1_idx",   64'(out_idx),   64'd0);
    cyc(); cyc(); cyc();
    chk("busy_at_idx3", 64'(busy),    64'd1);
    chk("last_at_idx3", 64'(out_last), 64'd1);
    cyc();
    chk("idle_after_4", 64'(busy), 64'd0);

    // Backpressure at idx 1 plus input isolation after capture
    done_in = 1'b1;
    push_std();
    cyc();
    done_in = 1'b0;
    acc_in  = '1;
    cyc();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("hold_idx", 64'(out_idx), 64'd1);
      chk("hold_acc", 64'(out_acc), 64'd20);
      chk("hold_exp", 64'(out_exp), 64'd2);
    end
    out_ready = 1'b1;
    wait_idle("bp_idle_timeout");

    // Overrun: second pulse at idx 1 is dropped
    load(10, 20, 30, 40, 1, 2, 3, 4);
    done_in = 1'b1;
    push_std();
    cyc();
    done_in = 1'b0;
    cyc();
    chk("ovr_pre", 64'(overrun), 64'd0);
    load(99, 98, 97, 96, 9, 9, 9, 9);
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    wait_idle("ovr_idle_timeout");
    cyc();
    chk("ovr_sticky", 64'(overrun), 64'd1);
    #3 rst = 1'b0;
    #1 chk("ovr_rst_clear", 64'(overrun), 64'd0);
    #2 rst = 1'b1;
    cyc();

    // Back-to-back recapture on the last transfer
    load(10, 20, 30, 40, 1, 2, 3, 4);
    done_in = 1'b1;
    push_std();
    cyc();
    done_in = 1'b0;
    cyc(); cyc(); cyc();
    chk("b2b_at3", 64'(out_idx), 64'd3);
    load(5, 6, 7, 8, 9, 10, 11, 12);
    done_in = 1'b1;
    push(0, 5'd9, 32'd5);
    push(1, 5'd10, 32'd6);
    push(2, 5'd11, 32'd7);
    push(3, 5'd12, 32'd8);
    cyc();
    done_in = 1'b0;
    chk("b2b_busy",    64'(busy),    64'd1);
    chk("b2b_idx0",    64'(out_idx), 64'd0);
    chk("b2b_acc5",    64'(out_acc), 64'd5);
    chk("b2b_overrun", 64'(overrun), 64'd0);
    wait_idle("b2b_idle_timeout");

    // Reset mid-drain at idx 2, with overrun already raised
    load(10, 20, 30, 40, 1, 2, 3, 4);
    done_in = 1'b1;
    push(0, 5'd1, 32'd10);
    push(1, 5'd2, 32'd20);
    cyc();
    done_in = 1'b0;
    cyc();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    chk("mid_idx2",    64'(out_idx), 64'd2);
    chk("mid_overrun", 64'(overrun), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",   64'(out_valid), 64'd0);
    chk("mid_rst_busy",    64'(busy),      64'd0);
    chk("mid_rst_overrun", 64'(overrun),   64'd0);
    #1 rst = 1'b1;
    cyc();
    chk("post_rst_idle", 64'(busy), 64'd0);
    load(5, 6, 7, 8, 9, 10, 11, 12);
    done_in = 1'b1;
    push(0, 5'd9, 32'd5);
    push(1, 5'd10, 32'd6);
    push(2, 5'd11, 32'd7);
    push(3, 5'd12, 32'd8);
    cyc();
    done_in = 1'b0;
    chk("post_rst_idx0", 64'(out_idx), 64'd0);
    wait_idle("post_rst_idle_timeout");

    cyc(); cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
